// File: rtl/ram_arb.sv
// Two-requester arbiter in front of a single-port synchronous-read data RAM, with lock-based ownership.
// Define RAM_ARB_RR_EN for round-robin conflict resolution; fixed priority (requester 0) otherwise.
module ram_arb #(
  parameter int DW = 16,
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_din,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_dout,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_din,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_dout,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state;
  logic          last_r;
  logic [AW-1:0] addr_hold;
  logic          vld0_p1;
  logic          vld1_p1;
  logic          win0;

  always_comb begin
`ifdef RAM_ARB_RR_EN
    win0 = last_r;
`else
    // last_r is still tracked but never steers fixed-priority arbitration
    win0 = last_r | 1'b1;
`endif
  end

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    case (state)
      OWN0: m0_gnt = m0_req;
      OWN1: m1_gnt = m1_req;
      default: begin
        if (m0_req && m1_req) begin
          m0_gnt = win0;
          m1_gnt = ~win0;
        end else begin
          m0_gnt = m0_req;
          m1_gnt = m1_req;
        end
      end
    endcase
  end

  // Idle cycles park the address so the RAM read register does not move
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = addr_hold;
    ram_din  = '0;
    if (m0_gnt) begin
      ram_we   = m0_we;
      ram_addr = m0_addr;
      ram_din  = m0_din;
    end else if (m1_gnt) begin
      ram_we   = m1_we;
      ram_addr = m1_addr;
      ram_din  = m1_din;
    end
  end

  // Stage 0 -> 1: grant registered into ownership state and read-valid strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_r    <= 1'b1;
      addr_hold <= '0;
      vld0_p1   <= 1'b0;
      vld1_p1   <= 1'b0;
    end else begin
      vld0_p1 <= m0_gnt & ~m0_we;
      vld1_p1 <= m1_gnt & ~m1_we;
      if (m0_gnt || m1_gnt)
        addr_hold <= ram_addr;
      case (state)
        IDLE: begin
          if (m0_gnt) begin
            last_r <= 1'b0;
            if (m0_lock)
              state <= OWN0;
          end else if (m1_gnt) begin
            last_r <= 1'b1;
            if (m1_lock)
              state <= OWN1;
          end
        end
        OWN0: if (!m0_lock) state <= IDLE;
        OWN1: if (!m1_lock) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign m0_rvalid = vld0_p1;
  assign m1_rvalid = vld1_p1;
  assign m0_dout   = ram_dout;
  assign m1_dout   = ram_dout;

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb: a behavioural RAM, an owner/last-winner/shadow-memory model checked every cycle,
// and directed vectors with literal expectations. Honours RAM_ARB_RR_EN when defined.
module tb_ram_arb;
  localparam int DW = 16;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_din = '0;
  logic          m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_din = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, ram_we;
  logic [DW-1:0] m0_dout, m1_dout, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  int n_chk = 0;
  int n_fail = 0;

  ram_arb #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_din(m0_din),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_din(m1_din),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_dout(m1_dout),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port RAM: the read address is captured only on non-write cycles
  logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: '0};
  logic [AW-1:0] ram_areg = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else        ram_areg <= ram_addr;
  end
  assign ram_dout = mem[ram_areg];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner (-1 none), last winner, pending read, shadow memory
  logic [DW-1:0] shadow [0:(1<<AW)-1] = '{default: '0};
  int            own = -1;
  int            last = 1;
  bit            pv0 = 0, pv1 = 0;
  logic [DW-1:0] pd = '0;
  logic [AW-1:0] hold = '0;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      own = -1; last = 1; pv0 = 0; pv1 = 0; hold = '0;
    end else begin
      bit e0, e1, ewe;
      int w;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      e0 = 0; e1 = 0;
      if (own == 0) e0 = m0_req;
      else if (own == 1) e1 = m1_req;
      else if (m0_req && m1_req) begin
`ifdef RAM_ARB_RR_EN
        w = 1 - last;
`else
        w = 0;
`endif
        e0 = (w == 0); e1 = (w == 1);
      end else begin
        e0 = m0_req; e1 = m1_req;
      end
      ewe = 0; ea = hold; ed = '0;
      if (e0) begin ewe = m0_we; ea = m0_addr; ed = m0_din; end
      else if (e1) begin ewe = m1_we; ea = m1_addr; ed = m1_din; end
      chk("m_gnt0", m0_gnt, e0);
      chk("m_gnt1", m1_gnt, e1);
      chk("m_ram_we", ram_we, ewe);
      chk("m_ram_addr", ram_addr, ea);
      chk("m_ram_din", ram_din, ed);
      chk("m_rvalid0", m0_rvalid, pv0);
      chk("m_rvalid1", m1_rvalid, pv1);
      if (pv0) chk("m_dout0", m0_dout, pd);
      if (pv1) chk("m_dout1", m1_dout, pd);
      pv0 = e0 && !m0_we;
      pv1 = e1 && !m1_we;
      if (e0 || e1) begin
        if (ewe) shadow[ea] = ed;
        else     pd = shadow[ea];
        hold = ea;
      end
      if (own == -1) begin
        if (e0 || e1) last = e1 ? 1 : 0;
        if (e0 && m0_lock) own = 0;
        else if (e1 && m1_lock) own = 1;
      end else if (own == 0 && !m0_lock) own = -1;
      else if (own == 1 && !m1_lock) own = -1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_din = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_din = '0;
  endtask

  initial begin
    idle_in();
    repeat (3) cyc();
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_rvalid0", m0_rvalid, 0);
    chk("rst_rvalid1", m1_rvalid, 0);
    rst = 1;

    // write then read back through requester 0
    cyc(); m0_req = 1; m0_we = 1; m0_addr = 13'h0005; m0_din = 16'hBEEF;
    #1 chk("t1_wr_gnt", m0_gnt, 1); chk("t1_wr_we", ram_we, 1); chk("t1_wr_din", ram_din, 16'hBEEF);
    cyc(); m0_we = 0;
    #1 chk("t1_rd_gnt", m0_gnt, 1); chk("t1_rd_we", ram_we, 0);
    cyc(); idle_in();
    #1 chk("t1_rvalid0", m0_rvalid, 1); chk("t1_dout0", m0_dout, 16'hBEEF); chk("t1_rvalid1", m1_rvalid, 0);

    // idle cycles park the last read address
    cyc(); m0_req = 1; m0_we = 1; m0_addr = 13'h0010; m0_din = 16'hABCD;
    cyc(); m0_we = 0;
    cyc(); idle_in();
    #1 chk("t4_dout0", m0_dout, 16'hABCD);
    cyc();
    #1 chk("t4_we", ram_we, 0); chk("t4_addr", ram_addr, 13'h0010); chk("t4_din", ram_din, 0);
    chk("t4_rv0", m0_rvalid, 0); chk("t4_rv1", m1_rvalid, 0);

    // preload via the loader port, then continuous conflicting reads
    cyc(); m1_req = 1; m1_we = 1; m1_addr = 13'h1; m1_din = 16'h1111;
    cyc(); m1_addr = 13'h2; m1_din = 16'h2222;
    for (int i = 0; i < 6; i++) begin
      bit eg0, prev0;
      cyc();
      m0_req = 1; m0_we = 0; m0_addr = 13'h1; m1_req = 1; m1_we = 0; m1_addr = 13'h2;
`ifdef RAM_ARB_RR_EN
      eg0 = (i % 2 == 0);
      prev0 = ((i - 1) % 2 == 0);
`else
      eg0 = 1;
      prev0 = 1;
`endif
      #1 chk("t2_gnt0", m0_gnt, eg0); chk("t2_gnt1", m1_gnt, !eg0);
      if (i > 0) begin
        chk("t2_rv0", m0_rvalid, prev0);
        chk("t2_rv1", m1_rvalid, !prev0);
        chk("t2_dout", m0_dout, prev0 ? 16'h1111 : 16'h2222);
      end
    end

    // m1 locks for four accesses while m0 keeps asking
    cyc(); m0_req = 0; m1_req = 1; m1_lock = 1;
    #1 chk("t3_gnt1_0", m1_gnt, 1);
    for (int i = 1; i < 4; i++) begin
      cyc(); m0_req = 1; m1_lock = (i < 3);
      #1 chk("t3_gnt1", m1_gnt, 1); chk("t3_gnt0", m0_gnt, 0);
    end
    cyc(); m1_req = 0; m1_lock = 0;
    #1 chk("t3_release_gnt0", m0_gnt, 1);

    // asynchronous reset while m0 owns the RAM with a read outstanding
    cyc(); m0_req = 1; m0_we = 0; m0_addr = 13'h5; m0_lock = 1; m1_req = 0;
    #1 chk("t5_gnt0", m0_gnt, 1);
    cyc(); m0_req = 0; m1_req = 1; m1_addr = 13'h2;
    #1 chk("t5_rv0_pre", m0_rvalid, 1); chk("t5_owned_gnt1", m1_gnt, 0);
    #1 rst = 0;
    #1 chk("t5_rv0_rst", m0_rvalid, 0); chk("t5_idle_gnt1", m1_gnt, 1);
    idle_in();
    cyc(); rst = 1;
    cyc(); m0_req = 1; m0_addr = 13'h5; m1_req = 1; m1_addr = 13'h2;
    #1 chk("t5_first_gnt0", m0_gnt, 1); chk("t5_first_gnt1", m1_gnt, 0);

    // write/read collision on the same address
    cyc(); m0_req = 0; m1_addr = 13'h5;
    #1 chk("t6_pre_gnt1", m1_gnt, 1);
    cyc(); m0_req = 1; m0_we = 1; m0_addr = 13'h7; m0_din = 16'h1234; m1_addr = 13'h7;
    #1 chk("t6_gnt0", m0_gnt, 1); chk("t6_gnt1", m1_gnt, 0);
    cyc(); m0_req = 0; m0_we = 0;
    #1 chk("t6_next_gnt1", m1_gnt, 1);
    cyc();
    #1 chk("t6_rv1", m1_rvalid, 1); chk("t6_dout1", m1_dout, 16'h1234);
    cyc(); m1_req = 0; m0_req = 1; m0_we = 1; m0_addr = 13'h7; m0_din = 16'h5678;
    #1 chk("t6_prewrite_rv1", m1_rvalid, 1); chk("t6_prewrite_dout", m1_dout, 16'h1234);
    cyc(); idle_in();
    #1 chk("t6_end_rv1", m1_rvalid, 0);
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
